// File: rtl/imem_port_arbiter.sv
// ============================================================================
// Module      : imem_port_arbiter
// Description : Shares one single-port synchronous instruction RAM between
//               fetch (I) and data (D) ports; one access per RAM cycle,
//               ack one cycle after issue. Optional macro: ARB_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_port_arbiter #(
    parameter int         ADDR_W = 12,
    parameter logic [3:0] REGION = 4'b0001,
    parameter bit         RR_EN  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic [3:0]        d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]       conflict_cnt,
    output logic [31:0]       i_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;
    logic              hit_q, hit_d;
    logic              load_q, load_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic        i_elig, d_elig, grant_i, grant_d, hit;
    logic [31:0] sel_addr;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{i_addr, d_addr};

    always_comb begin
        // A port being acked this cycle still shows req high; skip it.
        i_elig   = i_req && (state_q != BUSY_I);
        d_elig   = d_req && (state_q != BUSY_D);
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        if (rst_n) begin
            if (i_elig && d_elig) begin
                if (RR_EN && last_d_q) grant_i = 1'b1;
                else                   grant_d = 1'b1;
            end else if (d_elig) begin
                grant_d = 1'b1;
            end else if (i_elig) begin
                grant_i = 1'b1;
            end
        end

        sel_addr = grant_d ? d_addr : i_addr;
        hit      = (sel_addr[31:28] == REGION);

        state_d  = grant_d ? BUSY_D : (grant_i ? BUSY_I : IDLE);
        last_d_d = grant_d ? 1'b1 : (grant_i ? 1'b0 : last_d_q);
        hit_d    = hit;
        load_d   = grant_i || (d_we == 4'b0000);

        mem_en      = (grant_i || grant_d) && hit;
        mem_we      = (grant_d && hit) ? d_we : 4'b0000;
        mem_addr_d  = mem_en ? sel_addr[ADDR_W+1:2] : mem_addr_q;
        mem_wdata_d = mem_en ? d_wdata : mem_wdata_q;
        mem_addr    = rst_n ? mem_addr_d  : '0;
        mem_wdata   = rst_n ? mem_wdata_d : '0;

        // Completion side: outputs forced low while in reset so a
        // dropped in-flight access never shows an ack.
        i_ack   = rst_n && (state_q == BUSY_I);
        d_ack   = rst_n && (state_q == BUSY_D);
        i_err   = i_ack && !hit_q;
        d_err   = d_ack && !hit_q;
        i_rdata = (i_ack && hit_q && load_q) ? mem_rdata : 32'h0;
        d_rdata = (d_ack && hit_q && load_q) ? mem_rdata : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            hit_q       <= 1'b0;
            load_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            hit_q       <= hit_d;
            load_q      <= load_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef ARB_PERF_EN
    logic [31:0] conflict_cnt_q, conflict_cnt_d;
    logic [31:0] i_stall_cnt_q, i_stall_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q + {31'd0, (i_elig && d_elig)};
        i_stall_cnt_d  = i_stall_cnt_q + {31'd0, (i_req && !i_ack)};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflict_cnt_q <= '0;
            i_stall_cnt_q  <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
            i_stall_cnt_q  <= i_stall_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
    assign i_stall_cnt  = i_stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
// ============================================================================
// Module      : tb_imem_port_arbiter
// Description : Directed, table-driven bench for imem_port_arbiter with a
//               behavioural synchronous RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_port_arbiter;

    logic        clk, rst_n;
    logic        i_req, i_ack, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_ack, d_err;
    logic [3:0]  d_we;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
`ifdef ARB_PERF_EN
    logic [31:0] conflict_cnt, i_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    imem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_EN
        , .conflict_cnt(conflict_cnt), .i_stall_cnt(i_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM: read data valid the cycle after mem_en.
    logic [31:0] ram [0:4095];
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= ram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        is_d;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_en;
        logic [3:0]  exp_we;
        logic [11:0] exp_maddr;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [9];

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
        ram[4]    = 32'hDEAD_BEEF;
        ram[8]    = 32'hAAAA_AAAA;
        mem_rdata = 32'h0;

        //         is_d we     addr          wdata         en we     maddr  rdata          err
        vecs[0] = '{1'b0, 4'h0, 32'h1000_0010, 32'h0,        1'b1, 4'h0, 12'd4,  32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1'b1, 4'h3, 32'h1000_0020, 32'h1234_5678, 1'b1, 4'h3, 12'd8,  32'h0,         1'b0};
        vecs[2] = '{1'b0, 4'h0, 32'h1000_0020, 32'h0,        1'b1, 4'h0, 12'd8,  32'hAAAA_5678, 1'b0};
        vecs[3] = '{1'b1, 4'h0, 32'h1000_0023, 32'h0,        1'b1, 4'h0, 12'd8,  32'hAAAA_5678, 1'b0};
        vecs[4] = '{1'b1, 4'hF, 32'h4000_0000, 32'h5555_5555, 1'b0, 4'h0, 12'd8,  32'h0,         1'b1};
        vecs[5] = '{1'b0, 4'h0, 32'h2000_0000, 32'h0,        1'b0, 4'h0, 12'd8,  32'h0,         1'b1};
        vecs[6] = '{1'b1, 4'hF, 32'h1000_0040, 32'hCAFE_F00D, 1'b1, 4'hF, 12'd16, 32'h0,         1'b0};
        vecs[7] = '{1'b0, 4'h0, 32'h1000_0040, 32'h0,        1'b1, 4'h0, 12'd16, 32'hCAFE_F00D, 1'b0};
        vecs[8] = '{1'b1, 4'h0, 32'h1000_0010, 32'h0,        1'b1, 4'h0, 12'd4,  32'hDEAD_BEEF, 1'b0};

        // Reset with both requesters active.
        rst_n  = 1'b0;
        i_req  = 1'b1; i_addr = 32'h1000_0010;
        d_req  = 1'b1; d_we = 4'h0; d_addr = 32'h1000_0020; d_wdata = 32'h0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rst_out_or", {31'd0, |{i_ack, i_err, d_ack, d_err, mem_en, mem_we}}, 32'h0);
            chk("rst_rdata", i_rdata | d_rdata, 32'h0);
            chk("rst_maddr", {20'd0, mem_addr}, 32'h0);
            chk("rst_mwdata", mem_wdata, 32'h0);
        end

        // Release: D wins the first grant, then strict alternation.
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_grant_en", {31'd0, mem_en}, 32'd1);
        chk("first_grant_addr", {20'd0, mem_addr}, 32'd8);
        chk("first_grant_noack", {30'd0, i_ack, d_ack}, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            step();
            @(negedge clk);
            if (k % 2 == 1) begin
                chk("cont_d_ack", {30'd0, i_ack, d_ack}, 32'd1);
                chk("cont_d_rdata", d_rdata, 32'hAAAA_AAAA);
                chk("cont_i_grant_addr", {20'd0, mem_addr}, 32'd4);
            end else begin
                chk("cont_i_ack", {30'd0, i_ack, d_ack}, 32'd2);
                chk("cont_i_rdata", i_rdata, 32'hDEAD_BEEF);
                chk("cont_d_grant_addr", {20'd0, mem_addr}, 32'd8);
            end
            chk("cont_en", {31'd0, mem_en}, 32'd1);
        end
        // Requests dropped while D is in flight: its ack still pulses.
        step();
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("drop_d_ack", {30'd0, i_ack, d_ack}, 32'd1);
        chk("drop_no_grant", {31'd0, mem_en}, 32'd0);
        step();
        @(negedge clk);
        chk("drop_idle", {30'd0, i_ack, d_ack}, 32'd0);

        // Single transactions from the table.
        foreach (vecs[v]) begin
            step();
            if (vecs[v].is_d) begin
                d_req = 1'b1; d_we = vecs[v].we; d_addr = vecs[v].addr; d_wdata = vecs[v].wdata;
            end else begin
                i_req = 1'b1; i_addr = vecs[v].addr;
            end
            @(negedge clk);
            chk($sformatf("v%0d_mem_en", v), {31'd0, mem_en}, {31'd0, vecs[v].exp_en});
            chk($sformatf("v%0d_mem_we", v), {28'd0, mem_we}, {28'd0, vecs[v].exp_we});
            chk($sformatf("v%0d_mem_addr", v), {20'd0, mem_addr}, {20'd0, vecs[v].exp_maddr});
            if (vecs[v].is_d && vecs[v].exp_en)
                chk($sformatf("v%0d_mem_wdata", v), mem_wdata, vecs[v].wdata);
            step();
            @(negedge clk);
            if (vecs[v].is_d) begin
                chk($sformatf("v%0d_acks", v), {30'd0, i_ack, d_ack}, 32'd1);
                chk($sformatf("v%0d_rdata", v), d_rdata, vecs[v].exp_rdata);
                chk($sformatf("v%0d_err", v), {30'd0, i_err, d_err}, {31'd0, vecs[v].exp_err});
            end else begin
                chk($sformatf("v%0d_acks", v), {30'd0, i_ack, d_ack}, 32'd2);
                chk($sformatf("v%0d_rdata", v), i_rdata, vecs[v].exp_rdata);
                chk($sformatf("v%0d_err", v), {30'd0, i_err, d_err}, {vecs[v].exp_err, 1'b0});
            end
            chk($sformatf("v%0d_no_regrant", v), {31'd0, mem_en}, 32'd0);
            step();
            i_req = 1'b0; d_req = 1'b0;
        end

        // Lone fetch held high: issue, ack, issue, ack.
        step();
        i_req = 1'b1; i_addr = 32'h1000_0040;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("single_en", {31'd0, mem_en}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("single_ack", {31'd0, i_ack}, (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k % 2 == 1) chk("single_rdata", i_rdata, 32'hCAFE_F00D);
            step();
        end
        i_req = 1'b0;
        step();

        // Reset asserted during the BUSY_I cycle: the ack is dropped.
        i_req = 1'b1; i_addr = 32'h1000_0010;
        @(negedge clk);
        chk("rmid_issue", {31'd0, mem_en}, 32'd1);
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rmid_no_ack", {30'd0, i_ack, i_err}, 32'd0);
        chk("rmid_rdata", i_rdata, 32'h0);
        chk("rmid_en", {31'd0, mem_en}, 32'd0);
        step();
        rst_n = 1'b1; i_req = 1'b0;
        @(negedge clk);
        chk("rmid_after_ack", {30'd0, i_ack, d_ack}, 32'd0);
        chk("rmid_after_en", {31'd0, mem_en}, 32'd0);
        chk("rmid_after_addr", {20'd0, mem_addr}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares one single-port synchronous instruction/BIOS RAM between the fetch stage (I port) and the memory stage (D port). The D port carries loads and stores, including program loading into instruction memory.
- Decodes the upper address nibble to decide whether an access targets this RAM. Gates byte write enables to the RAM. Sequences one access per RAM cycle.
- Returns a one-cycle-later ack that the 3-stage pipeline uses as its stall release.

Parameters:
- ADDR_W, 12, RAM word-address width. Word address = addr[ADDR_W+1:2].
- REGION, 4'b0001, value of addr[31:28] that hits this RAM.
- RR_EN, 0: 0 = data port has fixed priority; 1 = round-robin between ports.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- i_req  in  1  fetch request; held high until i_ack
- i_addr  in  32  fetch byte address
- i_ack  out  1  one-cycle pulse; fetch complete
- i_rdata  out  32  fetch data; valid while i_ack
- i_err  out  1  pulse with i_ack when i_addr misses REGION
- d_req  in  1  data request; held high until d_ack
- d_we  in  4  byte write enables; 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_ack  out  1  one-cycle pulse; data access complete
- d_rdata  out  32  load data; valid while d_ack; 0 on stores
- d_err  out  1  pulse with d_ack on a region miss
- mem_en  out  1  RAM enable
- mem_we  out  4  RAM byte write enables
- mem_addr  out  ADDR_W  RAM word address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid the cycle after mem_en

Behaviour:
- Clocking and reset:
  - Single clock domain clk.
  - Reset is synchronous and active-low (rst_n).
  - While rst_n=0 at a rising edge, every output goes to 0: acks, errs, rdata, mem_en, mem_we, mem_addr, mem_wdata.
  - Reset also sets state IDLE and sets the RR pointer to favour D.
  - Reset mid-access drops the in-flight access: no ack is issued for it.
- FSM states: IDLE, BUSY_I, BUSY_D.
  - The state names the in-flight owner; it lasts exactly one cycle per access.
- Grant cycle N:
  - Eligible requesters are those with req=1, excluding any requester being acked in cycle N (its req is still high that cycle).
  - Both eligible, RR_EN=0: D wins.
  - Both eligible, RR_EN=1: the port not granted last wins; the pointer updates on every grant.
  - One eligible: it wins.
  - None eligible: next state IDLE.
- Issue (cycle N, combinational from the grant):
  - If addr[31:28]==REGION: mem_en=1, mem_addr=addr[ADDR_W+1:2], mem_we=d_we for D and 4'b0 for I, mem_wdata=d_wdata.
  - On a miss: mem_en=0 and mem_we=0. The access still consumes the slot.
  - With no grant, mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their last values.
- Complete (cycle N+1, registered owner):
  - The owner's ack=1.
  - rdata = mem_rdata on a hit load, 0 on a store or miss.
  - err=1 on a miss.
  - The non-owner's ack, err and rdata are 0.
- Throughput:
  - A new grant may issue in an ack cycle, so alternating I/D traffic sustains one access per cycle.
  - A single requester sees 50% throughput: ack cycle, then regrant.
- Latency: request seen in cycle N with no contention → ack in N+1.
- Address handling: addr[1:0] is ignored; misalignment is the core's responsibility.
- Stores: a write completes at the end of cycle N. A fetch to the same word granted in N+1 returns the new data.
- Requests dropped before ack (protocol violation): the access still completes and the ack is still pulsed.

Optional Feature:
- Macro ARB_PERF_EN.
- Defined:
  - Adds output ports conflict_cnt[31:0] and i_stall_cnt[31:0], both reset to 0 and wrapping at 2^32.
  - conflict_cnt increments each cycle in which both requesters are eligible.
  - i_stall_cnt increments each cycle with i_req=1 and i_ack=0.
- Undefined: no counters and no extra ports; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 2 cycles with both reqs high → all outputs 0 and no ack. Release → first grant to D.
- Lone fetch: i_addr=0x1000_0010, RAM word 4 = 0xDEAD_BEEF → mem_en=1 and mem_addr=4 in N; i_ack=1 and i_rdata=0xDEADBEEF in N+1.
- Contention, RR_EN=0, both reqs held → grants D,I,D,I…. The first two grants are D then I, and D is chosen whenever both are eligible.
- Store then fetch: d_we=4'b0011, d_addr=0x1000_0020, d_wdata=0x1234_5678 over old value 0xAAAA_AAAA → mem_we=4'b0011 and mem_addr=8; a following fetch of word 8 returns 0xAAAA_5678.
- Miss: d_addr=0x4000_0000, d_we=4'hF → mem_en=0 and mem_we=0; next cycle d_ack=1, d_err=1, d_rdata=0.
- Reset mid-access: assert rst_n=0 in a BUSY_I cycle → no i_ack follows; outputs 0 the next cycle.
